sram_access_ctrl: RTL and testbench



---
 rtl/sram_access_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Single-request SRAM phase sequencer: precharge -> word-line access -> one-cycle response.
// Latency accept->rsp_valid is P+A+1 cycles; req_ready is held low until the sequence returns to IDLE.
module sram_access_ctrl #(
  parameter int WIDTH            = 8,
  parameter int PRECHARGE_CYCLES = 1,
  parameter int ACCESS_CYCLES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [2:0]       dec_address,
  output logic             dec_valid,
  output logic             precharge,
  output logic             wr_en,
  output logic [WIDTH-1:0] bit_wdata,
  output logic             sense_en,
  input  logic [WIDTH-1:0] sense_data
);

  typedef enum logic [1:0] {IDLE, PRE, ACCESS, RESP} state_t;

  localparam logic [3:0] PRE_LOAD = 4'(PRECHARGE_CYCLES - 1);
  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_write;
  logic [2:0]       r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_rdata;
  logic [2:0]       r_dec_address;
  logic             r_dec_valid;
  logic             r_precharge;
  logic             r_wr_en;
  logic [WIDTH-1:0] r_bit_wdata;
  logic             r_sense_en;

  logic w_accept;
  logic w_phase_done;

  assign w_accept     = req_valid && r_req_ready;
  assign w_phase_done = (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_write       <= 1'b0;
      r_addr        <= 3'd0;
      r_wdata       <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_dec_address <= 3'd0;
      r_dec_valid   <= 1'b0;
      r_precharge   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_bit_wdata   <= '0;
      r_sense_en    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Also raises req_ready in the first cycle after reset release.
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_precharge <= 1'b1;
            r_cnt       <= PRE_LOAD;
            r_state     <= PRE;
          end
        end
        PRE: begin
          if (w_phase_done) begin
            r_precharge   <= 1'b0;
            r_dec_valid   <= 1'b1;
            r_dec_address <= r_addr;
            r_wr_en       <= r_write;
            r_bit_wdata   <= r_write ? r_wdata : '0;
            r_sense_en    <= !r_write && (ACC_LOAD == 4'd0);
            r_cnt         <= ACC_LOAD;
            r_state       <= ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACCESS: begin
          if (w_phase_done) begin
            if (r_sense_en) begin
              r_rsp_rdata <= sense_data;
            end
            r_dec_valid   <= 1'b0;
            r_dec_address <= 3'd0;
            r_wr_en       <= 1'b0;
            r_bit_wdata   <= '0;
            r_sense_en    <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            // Sense only in the final access cycle, when the bit lines have fully split.
            r_sense_en <= !r_write && (r_cnt == 4'd1);
            r_cnt      <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign dec_address = r_dec_address;
  assign dec_valid   = r_dec_valid;
  assign precharge   = r_precharge;
  assign wr_en       = r_wr_en;
  assign bit_wdata   = r_bit_wdata;
  assign sense_en    = r_sense_en;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (P=1/A=2 and P=3/A=4), an array model on the
// column side, a timeline reference model and a response scoreboard.
module tb_sram_access_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     [2];
  logic         req_valid [2];
  logic         req_ready [2];
  logic         req_write [2];
  logic [2:0]   req_addr  [2];
  logic [W-1:0] req_wdata [2];
  logic         rsp_valid [2];
  logic [W-1:0] rsp_rdata [2];
  logic [2:0]   dec_address [2];
  logic         dec_valid [2];
  logic         precharge [2];
  logic         wr_en     [2];
  logic [W-1:0] bit_wdata [2];
  logic         sense_en  [2];
  logic [W-1:0] sense_data [2];

  sram_access_ctrl #(.WIDTH(W), .PRECHARGE_CYCLES(1), .ACCESS_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .dec_address(dec_address[0]),
    .dec_valid(dec_valid[0]), .precharge(precharge[0]), .wr_en(wr_en[0]),
    .bit_wdata(bit_wdata[0]), .sense_en(sense_en[0]), .sense_data(sense_data[0])
  );

  sram_access_ctrl #(.WIDTH(W), .PRECHARGE_CYCLES(3), .ACCESS_CYCLES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .dec_address(dec_address[1]),
    .dec_valid(dec_valid[1]), .precharge(precharge[1]), .wr_en(wr_en[1]),
    .bit_wdata(bit_wdata[1]), .sense_en(sense_en[1]), .sense_data(sense_data[1])
  );

  function automatic int pc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int ac(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", name, d, cyc, got, exp);
    end
  endtask

  // Column-side array: stores on wr_en, returns the addressed word while sense_en is high
  // and the inverted word otherwise, so a mistimed capture shows up.
  logic [W-1:0] arr [2][8] = '{default: '0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en[d] && dec_valid[d]) arr[d][dec_address[d]] <= bit_wdata[d];
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      sense_data[d] = sense_en[d] ? arr[d][dec_address[d]] : ~arr[d][dec_address[d]];
    end
  end

  typedef struct {
    logic [W-1:0] rdata;
    int           due;
  } exp_t;

  exp_t sb0 [$];
  exp_t sb1 [$];

  // Reference model: a transaction is a timeline of cycles after acceptance.
  bit           m_busy  [2] = '{0, 0};
  bit           m_ready [2] = '{0, 0};
  int           m_k     [2] = '{0, 0};
  bit           m_wr    [2];
  logic [2:0]   m_addr  [2];
  logic [W-1:0] m_wdata [2];
  logic [W-1:0] m_rdata [2] = '{default: '0};
  logic [W-1:0] m_rd_new [2];
  logic [W-1:0] ref_mem [2][8] = '{default: '0};
  int           acc_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int P, A, k;
      logic e_pre, e_dec, e_wr, e_se, e_rsp, e_rdy;
      exp_t e;
      P = pc(d);
      A = ac(d);
      k = m_k[d];
      if (!rst_n[d]) begin
        chk("reset_outputs", d, {7'd0, req_ready[d], rsp_valid[d], rsp_rdata[d], dec_address[d],
            dec_valid[d], precharge[d], wr_en[d], bit_wdata[d], sense_en[d]}, 32'd0);
        m_busy[d]  = 1'b0;
        m_ready[d] = 1'b0;
        m_rdata[d] = '0;
        if (d == 0) sb0.delete(); else sb1.delete();
      end else begin
        e_pre = m_busy[d] && k >= 1 && k <= P;
        e_dec = m_busy[d] && k > P && k <= P + A;
        e_wr  = e_dec && m_wr[d];
        e_se  = m_busy[d] && !m_wr[d] && k == P + A;
        e_rsp = m_busy[d] && k == P + A + 1;
        e_rdy = !m_busy[d] && m_ready[d];
        if (e_rsp && !m_wr[d]) m_rdata[d] = m_rd_new[d];
        chk("req_ready", d, req_ready[d], e_rdy);
        chk("precharge", d, precharge[d], e_pre);
        chk("dec_valid", d, dec_valid[d], e_dec);
        chk("wr_en",     d, wr_en[d], e_wr);
        chk("sense_en",  d, sense_en[d], e_se);
        chk("rsp_valid", d, rsp_valid[d], e_rsp);
        chk("rsp_rdata_hold", d, rsp_rdata[d], m_rdata[d]);
        if (e_dec) chk("dec_address", d, dec_address[d], m_addr[d]);
        if (e_wr)  chk("bit_wdata", d, bit_wdata[d], m_wdata[d]);
        chk("inv_pre_dec", d, precharge[d] && dec_valid[d], 1'b0);
        chk("inv_wr_se",   d, wr_en[d] && sense_en[d], 1'b0);
        chk("inv_ctl_dec", d, (wr_en[d] || sense_en[d]) && !dec_valid[d], 1'b0);

        if (m_busy[d]) begin
          if (k == P + A + 1) begin
            m_busy[d]  = 1'b0;
            m_ready[d] = 1'b1;
          end else begin
            m_k[d] = k + 1;
          end
        end else if (m_ready[d] && req_valid[d]) begin
          m_busy[d]  = 1'b1;
          m_k[d]     = 1;
          m_wr[d]    = req_write[d];
          m_addr[d]  = req_addr[d];
          m_wdata[d] = req_wdata[d];
          if (req_write[d]) begin
            ref_mem[d][req_addr[d]] = req_wdata[d];
            e.rdata = m_rdata[d];
          end else begin
            m_rd_new[d] = ref_mem[d][req_addr[d]];
            e.rdata = m_rd_new[d];
          end
          e.due = cyc + P + A + 1;
          if (d == 0) sb0.push_back(e); else sb1.push_back(e);
          acc_cnt[d]++;
        end else begin
          m_ready[d] = 1'b1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a DUT presents rsp_valid.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      int   sz;
      sz = (d == 0) ? sb0.size() : sb1.size();
      if (rst_n[d] && rsp_valid[d] === 1'b1) begin
        if (sz == 0) begin
          chk("rsp_unexpected", d, rsp_valid[d], 1'b0);
        end else begin
          if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
          chk("rsp_cycle", d, cyc, e.due);
          chk("rsp_rdata", d, rsp_rdata[d], e.rdata);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and returns just after the accepting edge (inside cycle 1).
  task automatic issue(input int d, input logic w, input logic [2:0] a, input logic [W-1:0] dat,
                       input bit keep);
    int start;
    bit got;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = dat;
    req_valid[d] = 1'b1;
    start = acc_cnt[d];
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt[d] != start) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d got=no_accept exp=accept", d);
    end
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic random_ops(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      issue(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            (i != n - 1) && ($urandom_range(0, 2) == 0));
      if (!req_valid[d]) idle_cycles($urandom_range(0, 6));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = 3'd7;
      req_wdata[d] = 8'hFF;
    end
    idle_cycles(3);
    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b1;
      req_valid[d] = 1'b0;
    end
    idle_cycles(4);

    fork
      begin
        issue(0, 1'b1, 3'd5, 8'hA5, 1'b0);
        idle_cycles(5);
        issue(0, 1'b0, 3'd5, 8'h00, 1'b0);
        idle_cycles(5);
        issue(0, 1'b1, 3'd3, 8'h3C, 1'b0);
        idle_cycles(6);
        for (int a = 0; a < 8; a++) issue(0, 1'b1, 3'(a), 8'($urandom), 1'b1);
        for (int a = 0; a < 8; a++) issue(0, 1'b0, 3'(a), 8'h00, a != 7);
        idle_cycles(6);
        issue(0, 1'b1, 3'd2, 8'h77, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_dec_valid", 0, dec_valid[0], 1'b0);
        chk("midrst_wr_en",     0, wr_en[0], 1'b0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        idle_cycles(10);
        issue(0, 1'b1, 3'd2, 8'h5A, 1'b0);
        idle_cycles(5);
        issue(0, 1'b0, 3'd2, 8'h00, 1'b0);
        idle_cycles(5);
        random_ops(0, 40);
      end
      begin
        issue(1, 1'b1, 3'd1, 8'hC3, 1'b0);
        idle_cycles(9);
        issue(1, 1'b0, 3'd1, 8'h00, 1'b0);
        idle_cycles(9);
        random_ops(1, 25);
      end
    join

    idle_cycles(15);
    chk("sb_empty", 0, sb0.size(), 0);
    chk("sb_empty", 1, sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
